// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide memory port between two requesters with registered memory-side outputs
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_data_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [1:0]        grant_o,
  output logic              busy_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0] state;
  logic       last;
  logic [1:0] mask;
  logic [1:0] elig;
  logic       win1;
  logic       done;
  assign elig = {p1_enable_i & ~mask[1], p0_enable_i & ~mask[0]};
  // Port 1 takes a tie under fixed priority, or when port 0 owned the port last.
  assign win1 = elig[1] & (~elig[0] | (PRIO_MODE != 0) | ~last);
  assign busy_o = state == BUSY;
  assign done = busy_o & mem_ack_i;
  assign p0_ack_o = done & grant_o[0];
  assign p1_ack_o = done & grant_o[1];
  assign p0_data_o = mem_data_i;
  assign p1_data_o = mem_data_i;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      last         <= 1'b1;
      mask         <= '0;
      grant_o      <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else if (state == IDLE) begin
      mask <= '0;
      if (|elig) begin
        state        <= BUSY;
        grant_o      <= win1 ? 2'b10 : 2'b01;
        mem_enable_o <= 1'b1;
        mem_write_o  <= win1 ? p1_write_i : p0_write_i;
        mem_addr_o   <= win1 ? p1_addr_i : p0_addr_i;
        mem_data_o   <= win1 ? p1_data_i : p0_data_i;
      end
    end else if (mem_ack_i) begin
      state        <= IDLE;
      grant_o      <= '0;
      mem_enable_o <= 1'b0;
      last         <= grant_o[1];
      mask         <= grant_o;
    end
  end
endmodule
